seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display behind the AXI4-Lite seven-segment slave. Takes digit/control values from the slave's register file and double-buffers them into a shadow set at frame boundaries. Drives anodes one slot at a time, inserting anti-ghosting blank time and 16-level PWM brightness. Sits between the slave register outputs and the board pins.

---
 rtl/seven_seg_pkg.sv | 37 +++
 rtl/seven_seg_decoder.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment lookup for the seven-segment scan path.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } scan_state_e;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF    = 7'h7F;

    // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    always_comb seg_n_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed display scanner with anti-ghost blanking, PWM dimming
// and frame-boundary double buffering of the digit/control values.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        enable,
    input  logic [15:0] digit_data,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp,
    input  logic [3:0]  brightness,
    input  logic        update,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_done,
    output logic        update_pending
);

    localparam int unsigned   CW         = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [1:0]    LAST_DIGIT = 2'(NUM_DIGITS - 1);

    scan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [15:0]   sh_data_q, sh_data_d;
    logic [3:0]    sh_en_q, sh_en_d;
    logic [3:0]    sh_dp_q, sh_dp_d;
    logic [3:0]    sh_br_q, sh_br_d;
    logic          pend_q, pend_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dpn_q, dpn_d;
    logic          fdone_q, fdone_d;
    logic          reload;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        pwm_d     = pwm_q;
        sh_data_d = sh_data_q;
        sh_en_d   = sh_en_q;
        sh_dp_d   = sh_dp_q;
        sh_br_d   = sh_br_q;
        pend_d    = pend_q;
        fdone_d   = 1'b0;
        reload    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            pwm_d   = '0;
            pend_d  = 1'b0;
        end else begin
            // cnt runs across the whole slot: blank occupies 0..BLANK_LAST, drive the rest.
            case (state_q)
                IDLE: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                    reload  = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        pwm_d   = '0;
                    end
                end
                DRIVE: begin
                    pwm_d = pwm_q + 4'd1;
                    if (cnt_q == SLOT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        if (idx_q == LAST_DIGIT) begin
                            fdone_d = 1'b1;
                            reload  = pend_q;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (reload)
                pend_d = 1'b0;
            else if (update && state_q != IDLE)
                pend_d = 1'b1;
        end
        if (reload) begin
            sh_data_d = digit_data;
            sh_en_d   = digit_en;
            sh_dp_d   = dp;
            sh_br_d   = brightness;
        end
    end

    // Outputs are derived from next-state values so the registered pins line up with the state.
    assign nibble = sh_data_d[{idx_d, 2'b00} +: 4];

    seven_seg_decoder u_decoder (
        .nibble_i (nibble),
        .seg_n_o  (seg_dec)
    );

    always_comb begin
        an_d  = 4'hF;
        seg_d = SEG_OFF;
        dpn_d = 1'b1;
        if (state_d == DRIVE) begin
            seg_d        = seg_dec;
            dpn_d        = ~sh_dp_d[idx_d];
            an_d[idx_d]  = ~(sh_en_d[idx_d] && (pwm_d <= sh_br_d));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pwm_q     <= '0;
            sh_data_q <= '0;
            sh_en_q   <= '0;
            sh_dp_q   <= '0;
            sh_br_q   <= '0;
            pend_q    <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dpn_q     <= 1'b1;
            fdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pwm_q     <= pwm_d;
            sh_data_q <= sh_data_d;
            sh_en_q   <= sh_en_d;
            sh_dp_q   <= sh_dp_d;
            sh_br_q   <= sh_br_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dpn_q     <= dpn_d;
            fdone_q   <= fdone_d;
        end
    end

    assign an_n           = an_q;
    assign seg_n          = seg_q;
    assign dp_n           = dpn_q;
    assign frame_done     = fdone_q;
    assign update_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: constant vector table, hand corner sequences and
// a randomized run against an elapsed-time reference model.
module tb_seven_seg_scan_ctrl;

    localparam int SLOT  = 20;
    localparam int BLANK = 4;
    localparam int FRAME = 4 * SLOT;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] digit_data = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  brightness = '0;
    logic        update = 1'b0;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_done;
    logic        update_pending;

    seven_seg_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .enable         (enable),
        .digit_data     (digit_data),
        .digit_en       (digit_en),
        .dp             (dp),
        .brightness     (brightness),
        .update         (update),
        .an_n           (an_n),
        .seg_n          (seg_n),
        .dp_n           (dp_n),
        .frame_done     (frame_done),
        .update_pending (update_pending)
    );

    always #5 ACLK = ~ACLK;

    int n_err = 0;
    int n_chk = 0;
    int cur_t = 0;
    logic chk_on = 1'b0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is just elapsed cycles since it started; everything follows from t.
    logic        m_scan = 1'b0;
    int          m_t = 0;
    logic        m_pend = 1'b0;
    logic        m_fd = 1'b0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_en = '0, m_dp = '0, m_br = '0;

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            m_scan = 1'b0; m_t = 0; m_pend = 1'b0; m_fd = 1'b0;
            m_data = '0; m_en = '0; m_dp = '0; m_br = '0;
        end else if (!enable) begin
            m_scan = 1'b0; m_pend = 1'b0; m_fd = 1'b0;
        end else if (!m_scan) begin
            m_scan = 1'b1; m_t = 0; m_fd = 1'b0; m_pend = 1'b0;
            m_data = digit_data; m_en = digit_en; m_dp = dp; m_br = brightness;
        end else begin
            m_t++;
            m_fd = (m_t % FRAME == 0);
            if (m_fd && m_pend) begin
                m_data = digit_data; m_en = digit_en; m_dp = dp; m_br = brightness;
                m_pend = 1'b0;
            end else if (update) begin
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge ACLK) begin
        int o, s, p;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        logic [3:0] nib;
        if (chk_on) begin
            ea = 4'hF; es = 7'h7F; ed = 1'b1;
            if (m_scan) begin
                o = m_t % SLOT;
                s = (m_t / SLOT) % 4;
                if (o >= BLANK) begin
                    p   = (o - BLANK) % 16;
                    nib = m_data[4*s +: 4];
                    es  = seg_tab[nib];
                    ed  = ~m_dp[s];
                    if (m_en[s] && p <= int'(m_br)) ea[s] = 1'b0;
                end
            end
            check("model", {18'd0, an_n, seg_n, dp_n, frame_done, update_pending},
                           {18'd0, ea, es, ed, m_fd, m_pend});
        end
    end

    typedef struct packed {
        logic [15:0]      data;
        logic [3:0]       en;
        logic [3:0]       dpv;
        logic [3:0]       br;
        logic [3:0][7:0]  an_lo;
        logic [7:0]       dp_lo;
        logic [3:0][6:0]  seg;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] d, input logic [3:0] e, input logic [3:0] dv,
                                input logic [3:0] b, input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] a3, input logic [7:0] dl,
                                input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                                input logic [6:0] s3);
        vec_t v;
        v.data = d; v.en = e; v.dpv = dv; v.br = b;
        v.an_lo = {a3, a2, a1, a0};
        v.dp_lo = dl;
        v.seg = {s3, s2, s1, s0};
        return v;
    endfunction

    task automatic wait_t(input int target);
        repeat (target - cur_t) @(negedge ACLK);
        cur_t = target;
    endtask

    task automatic start_scan;
        enable = 1'b1;
        @(negedge ACLK);
        cur_t = 0;
    endtask

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(16'h3210, 4'hF, 4'h0, 4'hF, 16, 16, 16, 16, 0,
                     7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000);
        vecs[1] = mk(16'h3210, 4'hF, 4'h0, 4'h3, 4, 4, 4, 4, 0,
                     7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000);
        vecs[2] = mk(16'hBA98, 4'b0101, 4'b0001, 4'h7, 8, 0, 8, 0, 16,
                     7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011);
        vecs[3] = mk(16'hFEDC, 4'b1010, 4'b1000, 4'h0, 0, 1, 0, 1, 16,
                     7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110);
        vecs[4] = mk(16'h7654, 4'hF, 4'hF, 4'hF, 16, 16, 16, 16, 64,
                     7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000);

        repeat (3) @(negedge ACLK);
        check("rst_an", 32'(an_n), 32'hF);
        check("rst_seg", 32'(seg_n), 32'h7F);
        check("rst_dp", 32'(dp_n), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_pend", 32'(update_pending), 32'h0);
        ARESETN = 1'b1;
        chk_on = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 5; i++) begin
            int an_cnt [4];
            int dp_cnt, fd_cnt;
            logic [6:0] seen [4];
            enable = 1'b0;
            digit_data = vecs[i].data; digit_en = vecs[i].en;
            dp = vecs[i].dpv; brightness = vecs[i].br;
            @(negedge ACLK);
            start_scan();
            dp_cnt = 0; fd_cnt = 0;
            for (int d = 0; d < 4; d++) begin an_cnt[d] = 0; seen[d] = 7'h7F; end
            for (int k = 0; k < FRAME; k++) begin
                for (int d = 0; d < 4; d++) if (!an_n[d]) an_cnt[d]++;
                if (!dp_n) dp_cnt++;
                if (frame_done) fd_cnt++;
                if (seg_n != 7'h7F) seen[k / SLOT] = seg_n;
                wait_t(cur_t + 1);
            end
            for (int d = 0; d < 4; d++) begin
                check($sformatf("vec%0d_an%0d_on", i, d), 32'(an_cnt[d]), 32'(vecs[i].an_lo[d]));
                check($sformatf("vec%0d_seg%0d", i, d), 32'(seen[d]), 32'(vecs[i].seg[d]));
            end
            check($sformatf("vec%0d_dp_on", i), 32'(dp_cnt), 32'(vecs[i].dp_lo));
            check($sformatf("vec%0d_fd_in_frame", i), 32'(fd_cnt), 32'd0);
            check($sformatf("vec%0d_fd_at_80", i), 32'(frame_done), 32'd1);
        end

        // Shadowing: new data ignored until an update is taken at the frame boundary.
        enable = 1'b0;
        digit_data = 16'h3210; digit_en = 4'hF; dp = 4'h0; brightness = 4'hF;
        @(negedge ACLK);
        start_scan();
        wait_t(10);  digit_data = 16'hFFFF;
        wait_t(30);  update = 1'b1;
        wait_t(31);  update = 1'b0;
        check("upd_pending_set", 32'(update_pending), 32'd1);
        wait_t(79);
        check("upd_pending_hold", 32'(update_pending), 32'd1);
        check("upd_old_seg3", 32'(seg_n), 32'b0110000);
        wait_t(80);
        check("upd_pending_clr", 32'(update_pending), 32'd0);
        check("upd_fd", 32'(frame_done), 32'd1);
        wait_t(84);
        check("upd_new_seg0", 32'(seg_n), 32'b0001110);
        check("upd_new_an0", 32'(an_n), 32'hE);

        // Update landing on the reload edge is absorbed.
        wait_t(100); update = 1'b1;
        wait_t(101); update = 1'b0;
        wait_t(150); digit_data = 16'h0123;
        wait_t(159); update = 1'b1;
        wait_t(160); update = 1'b0;
        check("absorb_pending", 32'(update_pending), 32'd0);
        check("absorb_fd", 32'(frame_done), 32'd1);
        wait_t(164);
        check("absorb_seg0", 32'(seg_n), 32'b0110000);

        // Disable during digit 2 drive.
        wait_t(205); update = 1'b1;
        wait_t(206); update = 1'b0;
        wait_t(210); enable = 1'b0;
        wait_t(211);
        check("dis_an", 32'(an_n), 32'hF);
        check("dis_seg", 32'(seg_n), 32'h7F);
        check("dis_pend", 32'(update_pending), 32'd0);
        check("dis_fd", 32'(frame_done), 32'd0);
        wait_t(215);
        start_scan();
        wait_t(3);
        check("reen_blank_an", 32'(an_n), 32'hF);
        wait_t(4);
        check("reen_drive_an", 32'(an_n), 32'hE);
        check("reen_drive_seg", 32'(seg_n), 32'b0110000);

        // Asynchronous reset mid-drive with a request outstanding.
        wait_t(20); update = 1'b1;
        wait_t(21); update = 1'b0;
        wait_t(25);
        check("pre_rst_an", 32'(an_n), 32'hD);
        #2 ARESETN = 1'b0;
        #1;
        check("arst_an", 32'(an_n), 32'hF);
        check("arst_seg", 32'(seg_n), 32'h7F);
        check("arst_dp", 32'(dp_n), 32'd1);
        check("arst_pend", 32'(update_pending), 32'd0);
        check("arst_fd", 32'(frame_done), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        cur_t = 0;
        wait_t(4);
        check("post_rst_an", 32'(an_n), 32'hE);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge ACLK);
            enable = ($urandom_range(0, 199) != 0);
            update = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) begin
                digit_data = 16'($urandom);
                digit_en   = 4'($urandom);
                dp         = 4'($urandom);
                brightness = 4'($urandom);
            end
        end
        @(negedge ACLK);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
